// File: rtl/beamscaler_reader.sv
// rtl/beamscaler_reader.sv - scaler RAM sweep reader feeding a credit-gated 4-entry stream FIFO
// Define BEAMSCALER_READER_HDR_EN to prefix each frame with a sequence-numbered header word.
module beamscaler_reader #(
    parameter int NWORDS     = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        done_i,
    output logic        scal_rd_o,
    output logic [6:0]  scal_adr_o,
    input  logic [31:0] scal_dat_i,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy_o,
    output logic        overrun_o,
    input  logic        clear_i
);

    localparam logic [7:0]  LAST_ADR = 8'(NWORDS - 1);
    localparam logic [31:0] CAP_MASK = 32'h0FFF_0FFF;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
    state_t state, state_nxt;

    logic [7:0]            rd_cnt;
    logic                  rd_last_q;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [RD_LATENCY-1:0] last_pipe;
    logic [32:0]           fifo_mem [4];
    logic [32:0]           head;
    logic [32:0]           push_word;
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_cnt, credit;
    logic                  issue, pop, push, last_xfer, start, hdr_push;

    assign head      = fifo_mem[rd_ptr];
    assign m_tvalid  = (fifo_cnt != 3'd0);
    assign m_tdata   = m_tvalid ? head[31:0] : 32'h0;
    assign m_tlast   = m_tvalid & head[32];
    assign busy_o    = (state != IDLE);
    assign pop       = m_tvalid & m_tready;
    assign last_xfer = (state == DRAIN) & pop & m_tlast;
    // A done_i coinciding with the final transfer chains straight into the next sweep.
    assign start     = done_i & ((state == IDLE) | last_xfer);
    assign issue     = (state == SWEEP) & (credit < 3'd4);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (done_i) state_nxt = SWEEP;
            SWEEP:   if (issue && rd_cnt == LAST_ADR) state_nxt = DRAIN;
            DRAIN:   if (last_xfer) state_nxt = done_i ? SWEEP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rd_cnt     <= 8'd0;
            scal_rd_o  <= 1'b0;
            scal_adr_o <= 7'd0;
            rd_last_q  <= 1'b0;
            vld_pipe   <= '0;
            last_pipe  <= '0;
        end else begin
            if (start)      rd_cnt <= 8'd0;
            else if (issue) rd_cnt <= rd_cnt + 8'd1;
            scal_rd_o    <= issue;
            scal_adr_o   <= issue ? rd_cnt[6:0] : 7'd0;
            rd_last_q    <= issue & (rd_cnt == LAST_ADR);
            vld_pipe[0]  <= scal_rd_o;
            last_pipe[0] <= scal_rd_o & rd_last_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

`ifdef BEAMSCALER_READER_HDR_EN
    logic [15:0] frame_seq, seq_now;
    // The header of a chained sweep must already see the frame that is completing now.
    assign seq_now   = last_xfer ? frame_seq + 16'd1 : frame_seq;
    assign hdr_push  = start;
    assign push_word = hdr_push ? {1'b0, seq_now, 9'h000, LAST_ADR[6:0]}
                                : {last_pipe[RD_LATENCY-1], scal_dat_i & CAP_MASK};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) frame_seq <= 16'd0;
        else             frame_seq <= seq_now;
    end
`else
    assign hdr_push  = 1'b0;
    assign push_word = {last_pipe[RD_LATENCY-1], scal_dat_i & CAP_MASK};
`endif

    assign push = vld_pipe[RD_LATENCY-1] | hdr_push;

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr] <= push_word;
    end

    // Credit covers words still in the RAM pipe, so a full FIFO can never be pushed.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
            credit   <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + {2'b0, push} - {2'b0, pop};
            credit   <= credit + {2'b0, issue} + {2'b0, hdr_push} - {2'b0, pop};
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) overrun_o <= 1'b0;
        else             overrun_o <= (done_i & busy_o & ~start) | (overrun_o & ~clear_i);
    end

endmodule

// File: tb/tb_beamscaler_reader.sv
// tb/tb_beamscaler_reader.sv - directed self-checking bench for beamscaler_reader
module tb_beamscaler_reader;

`ifdef BEAMSCALER_READER_HDR_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_done, a_rd, a_tvalid, a_tready, a_tlast, a_busy, a_ovr, a_clear;
    logic [6:0]  a_adr;
    logic [31:0] a_dat, a_tdata, a_base;
    logic        b_done, b_rd, b_tvalid, b_tready, b_tlast, b_busy, b_ovr, b_clear;
    logic [6:0]  b_adr;
    logic [31:0] b_dat, b_tdata;

    beamscaler_reader #(.NWORDS(4), .RD_LATENCY(2)) u_a (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .done_i(a_done), .scal_rd_o(a_rd),
        .scal_adr_o(a_adr), .scal_dat_i(a_dat), .m_tdata(a_tdata), .m_tvalid(a_tvalid),
        .m_tready(a_tready), .m_tlast(a_tlast), .busy_o(a_busy), .overrun_o(a_ovr),
        .clear_i(a_clear));

    beamscaler_reader #(.NWORDS(1), .RD_LATENCY(1)) u_b (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .done_i(b_done), .scal_rd_o(b_rd),
        .scal_adr_o(b_adr), .scal_dat_i(b_dat), .m_tdata(b_tdata), .m_tvalid(b_tvalid),
        .m_tready(b_tready), .m_tlast(b_tlast), .busy_o(b_busy), .overrun_o(b_ovr),
        .clear_i(b_clear));

    // Scaler RAM models: two-cycle read for a, one-cycle read for b
    logic [6:0] a_aq1, a_aq2;
    logic       a_vq1, a_vq2;
    always @(posedge clk) begin
        a_aq1 <= a_adr; a_vq1 <= a_rd;
        a_aq2 <= a_aq1; a_vq2 <= a_vq1;
    end
    assign a_dat = a_vq2 ? a_base + {25'd0, a_aq2} : 32'hFFFF_FFFF;
    always @(posedge clk) b_dat <= b_rd ? 32'h1234_5678 + {25'd0, b_adr} : 32'hFFFF_FFFF;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [32:0] a_q[$];
    int          a_qc[$];
    logic [6:0]  a_ra[$];
    int          a_rc[$];
    logic [32:0] b_q[$];
    logic        a_stall = 1'b0, b_stall = 1'b0;
    logic [32:0] a_hold, b_hold;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (a_stall) begin
                check("a_hold_valid", {63'd0, a_tvalid}, 64'd1);
                check("a_hold_data", {31'd0, a_tlast, a_tdata}, {31'd0, a_hold});
            end
            if (b_stall) begin
                check("b_hold_valid", {63'd0, b_tvalid}, 64'd1);
                check("b_hold_data", {31'd0, b_tlast, b_tdata}, {31'd0, b_hold});
            end
            if (a_rd) begin a_ra.push_back(a_adr); a_rc.push_back(cyc); end
            if (a_tvalid && a_tready) begin a_q.push_back({a_tlast, a_tdata}); a_qc.push_back(cyc); end
            if (b_tvalid && b_tready) b_q.push_back({b_tlast, b_tdata});
            a_stall = a_tvalid && !a_tready;
            a_hold  = {a_tlast, a_tdata};
            b_stall = b_tvalid && !b_tready;
            b_hold  = {b_tlast, b_tdata};
        end
    end

    int a_frame_no = 0;
    int b_frame_no = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a_done();
        a_done = 1'b1; tick(); a_done = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while ((a_busy || a_tvalid) && n < 300) begin tick(); n++; end
        check(tag, {63'd0, (a_busy | a_tvalid)}, 64'd0);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp0);
        logic [32:0] w;
`ifdef BEAMSCALER_READER_HDR_EN
        w = '1;
        if (a_q.size() > 0) begin w = a_q.pop_front(); void'(a_qc.pop_front()); end
        check({tag, "_hdr"}, {31'd0, w}, {31'd0, 1'b0, a_frame_no[15:0], 16'h0003});
`endif
        a_frame_no++;
        for (int k = 0; k < 4; k++) begin
            w = '1;
            if (a_q.size() > 0) begin w = a_q.pop_front(); void'(a_qc.pop_front()); end
            check($sformatf("%s_w%0d", tag, k), {31'd0, w}, {31'd0, (k == 3), exp0 + 32'(k)});
        end
    endtask

    task automatic check_reads(input string tag, input bit b2b);
        check({tag, "_n"}, 64'(a_ra.size()), 64'd4);
        for (int k = 0; k < 4 && k < a_ra.size(); k++) begin
            check($sformatf("%s_adr%0d", tag, k), {57'd0, a_ra[k]}, 64'(k));
            if (b2b && k > 0) check($sformatf("%s_b2b%0d", tag, k), 64'(a_rc[k] - a_rc[k-1]), 64'd1);
        end
        a_ra.delete();
        a_rc.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {29'd0, a_rd, a_adr, a_tvalid, a_tlast, a_busy, a_ovr, a_tdata},
              64'd0);
        check({tag, "_b"}, {29'd0, b_rd, b_adr, b_tvalid, b_tlast, b_busy, b_ovr, b_tdata},
              64'd0);
    endtask

    initial begin
        int lat, n;
        logic [32:0] w;
        rst_n = 1'b0;
        a_done = 0; a_clear = 0; a_tready = 1; a_base = 32'h0ABC_0123;
        b_done = 0; b_clear = 0; b_tready = 1;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic frame, ready held high
        pulse_a_done();
        check("busy_rise", {63'd0, a_busy}, 64'd1);
        wait_idle_a("basic_idle");
        lat = (a_qc.size() > HOFF && a_rc.size() > 0) ? a_qc[HOFF] - a_rc[0] : -1;
        check("first_latency", 64'(lat), 64'd3);
        check_frame("basic", 32'h0ABC_0123);
        check_reads("basic_rd", 1'b1);
        check("basic_busy", {63'd0, a_busy}, 64'd0);

        // Backpressure: credit limit stalls the reads, data survives
        a_base = 32'hF00D_F00D;
        a_tready = 1'b0;
        pulse_a_done();
        repeat (20) tick();
        check("stall_reads", 64'(a_ra.size()), 64'(4 - HOFF));
        check("stall_valid", {63'd0, a_tvalid}, 64'd1);
        a_tready = 1'b1;
        wait_idle_a("stall_idle");
        check_frame("stall", 32'h000D_000D);
        check_reads("stall_rd", 1'b0);

        // Overrun: second done three cycles into a sweep
        a_base = 32'h0ABC_0123;
        pulse_a_done();
        tick(); tick();
        pulse_a_done();
        check("ovr_set", {63'd0, a_ovr}, 64'd1);
        wait_idle_a("ovr_idle");
        repeat (5) tick();
        check("ovr_no_restart", {63'd0, a_busy}, 64'd0);
        check("ovr_one_frame", 64'(a_q.size()), 64'(4 + HOFF));
        check_frame("ovr", 32'h0ABC_0123);
        check_reads("ovr_rd", 1'b0);

        // Clear and overrun event together: set wins
        pulse_a_done();
        tick();
        a_done = 1'b1; a_clear = 1'b1; tick(); a_done = 1'b0; a_clear = 1'b0;
        check("set_wins", {63'd0, a_ovr}, 64'd1);
        wait_idle_a("sw_idle");
        check_frame("sw", 32'h0ABC_0123);
        check_reads("sw_rd", 1'b0);
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        check("ovr_clear", {63'd0, a_ovr}, 64'd0);

        // Asynchronous reset at the second read
        pulse_a_done();
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (a_rd && a_adr == 7'd1) break;
            n++;
        end
        check("rst_found_rd1", 64'(n < 40), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        a_q.delete(); a_qc.delete(); a_ra.delete(); a_rc.delete(); b_q.delete();
        a_frame_no = 0; b_frame_no = 0;
        repeat (6) tick();
        check("rst_no_words", 64'(a_q.size()), 64'd0);
        check("rst_no_reads", 64'(a_ra.size()), 64'd0);
        check("rst_idle", {63'd0, a_busy}, 64'd0);
        pulse_a_done();
        wait_idle_a("rst_frame_idle");
        check_frame("post_rst", 32'h0ABC_0123);
        check_reads("post_rst_rd", 1'b1);

        // done_i on the final transfer chains a new sweep without overrun
        pulse_a_done();
        n = 0;
        while (!(a_tvalid && a_tlast) && n < 50) begin tick(); n++; end
        check("chain_found_last", 64'(n < 50), 64'd1);
        pulse_a_done();
        wait_idle_a("chain_idle");
        check("chain_no_ovr", {63'd0, a_ovr}, 64'd0);
        check("chain_reads", 64'(a_ra.size()), 64'd8);
        check_frame("chain1", 32'h0ABC_0123);
        check_frame("chain2", 32'h0ABC_0123);
        a_ra.delete(); a_rc.delete();

        // Single-word frames with random backpressure
        for (int i = 0; i < 5; i++) begin
            b_done = 1'b1; tick(); b_done = 1'b0;
            n = 0;
            while ((b_busy || b_tvalid) && n < 200) begin
                b_tready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            b_tready = 1'b1;
            check($sformatf("b_idle%0d", i), {63'd0, (b_busy | b_tvalid)}, 64'd0);
            check($sformatf("b_cnt%0d", i), 64'(b_q.size()), 64'(1 + HOFF));
`ifdef BEAMSCALER_READER_HDR_EN
            w = (b_q.size() > 0) ? b_q.pop_front() : '1;
            check($sformatf("b_hdr%0d", i), {31'd0, w}, {31'd0, 1'b0, b_frame_no[15:0], 16'h0000});
`endif
            w = (b_q.size() > 0) ? b_q.pop_front() : '1;
            check($sformatf("b_word%0d", i), {31'd0, w}, {31'd0, 1'b1, 32'h0234_0678});
            b_frame_no++;
        end
        check("b_no_ovr", {63'd0, b_ovr}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
